// File: rtl/ghost_mover_pkg.sv
// Shared types for the ghost mover: move directions, FSM state encoding and the
// default wall tile code.
package ghost_mover_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    PROBE  = 3'd2,
    CHECK  = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5
  } state_e;

  localparam logic [2:0] WALL_TYPE_DEFAULT = 3'd1;

  // UP/DOWN and LEFT/RIGHT differ only in bit 0.
  function automatic dir_e dir_opposite(input dir_e d);
    return dir_e'(d ^ 2'b01);
  endfunction

endpackage

// File: rtl/ghost_dir_rank.sv
// Ranks the four move directions for a ghost chasing pacman; order_o[1:0] is
// tried first, order_o[7:6] last.
module ghost_dir_rank
  import ghost_mover_pkg::*;
(
  input  logic signed [5:0] dx_i,
  input  logic signed [5:0] dy_i,
  output logic        [7:0] order_o
);

  logic [5:0] abs_dx;
  logic [5:0] abs_dy;
  dir_e       hor_tow;
  dir_e       ver_tow;

  always_comb begin
    abs_dx  = dx_i[5] ? 6'(-dx_i) : dx_i;
    abs_dy  = dy_i[5] ? 6'(-dy_i) : dy_i;
    // A zero delta counts as "toward" the positive direction.
    hor_tow = dx_i[5] ? LEFT : RIGHT;
    ver_tow = dy_i[5] ? UP   : DOWN;
    if (abs_dx >= abs_dy) begin
      order_o = {dir_opposite(hor_tow), dir_opposite(ver_tow), ver_tow, hor_tow};
    end else begin
      order_o = {dir_opposite(ver_tow), dir_opposite(hor_tow), hor_tow, ver_tow};
    end
  end

endmodule

// File: rtl/ghost_mover.sv
// Ghost movement controller: on each move tick, probes up to four neighbour tiles
// and writes the first open one to the ghost register. Define GHOST_MOVER_LFSR_EN
// to rotate the candidate order pseudo-randomly.
module ghost_mover
  import ghost_mover_pkg::*;
#(
  parameter int         MOVE_PERIOD = 5000000,
  parameter int         GRID_MAX    = 20,
  parameter logic [2:0] WALL_TYPE   = WALL_TYPE_DEFAULT
) (
  input  logic       clock_50,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [4:0] pac_x,
  input  logic [4:0] pac_y,
  input  logic [4:0] cur_x,
  input  logic [4:0] cur_y,
  output logic [4:0] map_x,
  output logic [4:0] map_y,
  input  logic [2:0] map_type,
  output logic [4:0] reg_x,
  output logic [4:0] reg_y,
  output logic       reg_en,
  output logic       reg_readwrite,
  output logic       move_done
);

  localparam int             CNT_W     = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_PERIOD - 1);
  localparam logic [4:0]     GRID_LAST = 5'(GRID_MAX);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                tick;
  logic [4:0]          pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [7:0]          order_q, order_d;
  logic [1:0]          idx_q, idx_d;
  logic [1:0]          slot;
  logic signed [5:0]   dx, dy;
  logic [7:0]          rank_order;
  dir_e                cand_dir;
  logic [4:0]          cand_x, cand_y;
  logic                off_grid;
  logic                blocked;

  assign tick = enable && (cnt_q == CNT_LAST);

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign dx = $signed({1'b0, pac_x}) - $signed({1'b0, cur_x});
  assign dy = $signed({1'b0, pac_y}) - $signed({1'b0, cur_y});

  ghost_dir_rank u_rank (
    .dx_i    (dx),
    .dy_i    (dy),
    .order_o (rank_order)
  );

`ifdef GHOST_MOVER_LFSR_EN
  logic [3:0] lfsr_q;
  logic [1:0] rot_q;

  // x^4 + x^3 + 1, free-running from reset.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= 4'b1001;
      rot_q  <= 2'd0;
    end else begin
      lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
      if (state_q == SAMPLE) rot_q <= lfsr_q[1:0];
    end
  end

  assign slot = idx_q + rot_q;
`else
  assign slot = idx_q;
`endif

  assign cand_dir = dir_e'(order_q[{slot, 1'b0} +: 2]);

  // Off-grid steps keep the current coordinate so the probe address never wraps.
  always_comb begin
    cand_x   = pos_x_q;
    cand_y   = pos_y_q;
    off_grid = 1'b0;
    case (cand_dir)
      UP:      if (pos_y_q == 5'd0)       off_grid = 1'b1; else cand_y = pos_y_q - 5'd1;
      DOWN:    if (pos_y_q >= GRID_LAST)  off_grid = 1'b1; else cand_y = pos_y_q + 5'd1;
      LEFT:    if (pos_x_q == 5'd0)       off_grid = 1'b1; else cand_x = pos_x_q - 5'd1;
      RIGHT:   if (pos_x_q >= GRID_LAST)  off_grid = 1'b1; else cand_x = pos_x_q + 5'd1;
      default: off_grid = 1'b1;
    endcase
  end

  assign blocked = off_grid || (map_type == WALL_TYPE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    order_d = order_q;
    case (state_q)
      IDLE: if (tick) state_d = SAMPLE;
      SAMPLE: begin
        pos_x_d = cur_x;
        pos_y_d = cur_y;
        order_d = rank_order;
        idx_d   = 2'd0;
        state_d = (dx == 6'sd0 && dy == 6'sd0) ? DONE : PROBE;
      end
      PROBE: state_d = CHECK;
      CHECK: begin
        if (!blocked) begin
          state_d = WRITE;
        end else if (idx_q == 2'd3) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = PROBE;
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      pos_x_q <= 5'd0;
      pos_y_q <= 5'd0;
      order_q <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      order_q <= order_d;
    end
  end

  assign map_x         = (state_q == PROBE) ? cand_x : 5'd0;
  assign map_y         = (state_q == PROBE) ? cand_y : 5'd0;
  assign reg_en        = (state_q == WRITE);
  assign reg_readwrite = !reg_en;
  assign reg_x         = reg_en ? cand_x : 5'd0;
  assign reg_y         = reg_en ? cand_y : 5'd0;
  assign move_done     = (state_q == DONE);

endmodule

// File: tb/tb_ghost_mover.sv
// Directed bench for ghost_mover with a registered map model (walls = type 1).
module tb_ghost_mover;
  import ghost_mover_pkg::*;

  logic       clock_50 = 1'b0;
  logic       reset_n  = 1'b0;
  logic       enable   = 1'b0;
  logic [4:0] pac_x = '0, pac_y = '0, cur_x = '0, cur_y = '0;
  logic [4:0] map_x, map_y, reg_x, reg_y;
  logic [2:0] map_type = '0;
  logic       reg_en, reg_readwrite, move_done;

  int         tests = 0;
  int         fails = 0;
  logic [4:0] wall_x [4];
  logic [4:0] wall_y [4];
  int         n_walls = 0;
  logic [4:0] probe_x [1:16];
  logic [4:0] probe_y [1:16];

  always #5 clock_50 = ~clock_50;

  ghost_mover #(.MOVE_PERIOD(4), .GRID_MAX(20), .WALL_TYPE(3'd1)) dut (
    .clock_50      (clock_50),
    .reset_n       (reset_n),
    .enable        (enable),
    .pac_x         (pac_x),
    .pac_y         (pac_y),
    .cur_x         (cur_x),
    .cur_y         (cur_y),
    .map_x         (map_x),
    .map_y         (map_y),
    .map_type      (map_type),
    .reg_x         (reg_x),
    .reg_y         (reg_y),
    .reg_en        (reg_en),
    .reg_readwrite (reg_readwrite),
    .move_done     (move_done)
  );

  // Open tiles alternate between codes 0 and 2 so only the exact wall code blocks.
  function automatic logic [2:0] tile(input logic [4:0] x, input logic [4:0] y);
    for (int i = 0; i < n_walls; i++)
      if (wall_x[i] == x && wall_y[i] == y) return 3'd1;
    return (x[0] ^ y[0]) ? 3'd2 : 3'd0;
  endfunction

  always @(posedge clock_50) map_type <= tile(map_x, map_y);

`ifdef GHOST_MOVER_LFSR_EN
  logic [3:0] m_lfsr;
  always @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 4'b1001;
    else          m_lfsr <= {m_lfsr[2:0], m_lfsr[3] ^ m_lfsr[2]};
  end
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic wait_tick(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock_50);
      if (dut.tick === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  // Samples cycles T+1..T+win (T = tick cycle); drops enable after cycle drop_at.
  task automatic run_move(input int win, input int drop_at,
                          output int en_cyc, output int en_cnt,
                          output logic [4:0] rx, output logic [4:0] ry,
                          output int done_cyc, output int done_cnt, output int rw_bad);
    en_cyc = -1; en_cnt = 0; rx = '0; ry = '0;
    done_cyc = -1; done_cnt = 0; rw_bad = 0;
    for (int k = 1; k <= win; k++) begin
      @(negedge clock_50);
      if (reg_en === 1'b1) begin
        en_cnt++;
        if (en_cyc < 0) begin
          en_cyc = k; rx = reg_x; ry = reg_y;
        end
        if (reg_readwrite !== 1'b0) rw_bad++;
      end else if (reg_readwrite !== 1'b1) begin
        rw_bad++;
      end
      if (move_done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      if (k <= 16) begin
        probe_x[k] = map_x;
        probe_y[k] = map_y;
      end
      if (k == drop_at) enable = 1'b0;
    end
    enable = 1'b0;
  endtask

  task automatic do_move(input string tag, input logic [4:0] cx, input logic [4:0] cy,
                         input logic [4:0] px, input logic [4:0] py,
                         input int win, input int drop_at, input int exp_en,
                         input logic [4:0] ex, input logic [4:0] ey, input int exp_done);
    int lat, en_cyc, en_cnt, done_cyc, done_cnt, rw_bad;
    logic [4:0] rx, ry;
    cur_x = cx; cur_y = cy; pac_x = px; pac_y = py;
    enable = 1'b1;
    wait_tick(lat);
    chk({tag, ".tick_seen"}, 32'(lat > 0), 1);
    run_move(win, drop_at, en_cyc, en_cnt, rx, ry, done_cyc, done_cnt, rw_bad);
    chk({tag, ".en_cnt"}, en_cnt, (exp_en > 0) ? 1 : 0);
    if (exp_en > 0) begin
      chk({tag, ".en_cyc"}, en_cyc, exp_en);
      chk({tag, ".reg_x"}, 32'(rx), 32'(ex));
      chk({tag, ".reg_y"}, 32'(ry), 32'(ey));
    end
    chk({tag, ".done_cyc"}, done_cyc, exp_done);
    chk({tag, ".done_cnt"}, done_cnt, 1);
    chk({tag, ".rw"}, rw_bad, 0);
  endtask

  initial begin
    int lat, en_cyc, en_cnt, done_cyc, done_cnt, rw_bad, seen;
    logic [4:0] rx, ry;

    // Reset state
    repeat (2) @(negedge clock_50);
    chk("rst.reg_en", 32'(reg_en), 0);
    chk("rst.reg_rw", 32'(reg_readwrite), 1);
    chk("rst.reg_x", 32'(reg_x), 0);
    chk("rst.reg_y", 32'(reg_y), 0);
    chk("rst.map_x", 32'(map_x), 0);
    chk("rst.map_y", 32'(map_y), 0);
    chk("rst.done", 32'(move_done), 0);
    chk("rst.cnt", 32'(dut.cnt_q), 0);
    chk("rst.state", 32'(dut.state_q), 32'(IDLE));
    reset_n = 1'b1;

`ifndef GHOST_MOVER_LFSR_EN
    // First move after reset: tick lands 3 cycles after enable with period 4.
    cur_x = 5'd2; cur_y = 5'd2; pac_x = 5'd10; pac_y = 5'd3; n_walls = 0;
    enable = 1'b1;
    wait_tick(lat);
    chk("t1.tick_lat", lat, 3);
    run_move(8, 1, en_cyc, en_cnt, rx, ry, done_cyc, done_cnt, rw_bad);
    chk("t1.en_cyc", en_cyc, 4);
    chk("t1.en_cnt", en_cnt, 1);
    chk("t1.reg_x", 32'(rx), 3);
    chk("t1.reg_y", 32'(ry), 2);
    chk("t1.probe_x", 32'(probe_x[2]), 3);
    chk("t1.done_cyc", done_cyc, 5);
    chk("t1.done_cnt", done_cnt, 1);
    chk("t1.rw", rw_bad, 0);

    // Wall on primary; enable stays high so the tick at T+4 must be dropped.
    n_walls = 1; wall_x[0] = 5'd3; wall_y[0] = 5'd2;
    do_move("t2", 5'd2, 5'd2, 5'd10, 5'd3, 7, 7, 6, 5'd2, 5'd3, 7);

    // All four blocked, third one off the left edge.
    n_walls = 3;
    wall_x[0] = 5'd0; wall_y[0] = 5'd4;
    wall_x[1] = 5'd1; wall_y[1] = 5'd5;
    wall_x[2] = 5'd0; wall_y[2] = 5'd6;
    do_move("t3", 5'd0, 5'd5, 5'd0, 5'd0, 12, 1, 0, 5'd0, 5'd0, 10);
    chk("t3.probe1_y", 32'(probe_y[2]), 4);
    chk("t3.probe2_x", 32'(probe_x[4]), 1);
    chk("t3.probe3_x", 32'(probe_x[6]), 0);
    chk("t3.probe4_y", 32'(probe_y[8]), 6);

    n_walls = 0;
    do_move("t4", 5'd7, 5'd7, 5'd7, 5'd7, 4, 1, 0, 5'd0, 5'd0, 2);
    do_move("t5", 5'd5, 5'd10, 5'd6, 5'd3, 6, 1, 4, 5'd5, 5'd9, 5);
    do_move("t6", 5'd20, 5'd4, 5'd28, 5'd4, 8, 1, 6, 5'd20, 5'd5, 7);
    do_move("t7", 5'd5, 5'd5, 5'd2, 5'd8, 6, 1, 4, 5'd4, 5'd5, 5);
`else
    cur_x = 5'd10; cur_y = 5'd10; pac_x = 5'd15; pac_y = 5'd12; n_walls = 0;
    for (int m = 0; m < 16; m++) begin
      logic [1:0] rot;
      logic [4:0] tx, ty;
      enable = 1'b1;
      wait_tick(lat);
      chk("lfsr.tick_seen", 32'(lat > 0), 1);
      @(negedge clock_50);
      rot = m_lfsr[1:0];
      enable = 1'b0;
      case (rot)
        2'd0:    begin tx = 5'd11; ty = 5'd10; end
        2'd1:    begin tx = 5'd10; ty = 5'd11; end
        2'd2:    begin tx = 5'd10; ty = 5'd9;  end
        default: begin tx = 5'd9;  ty = 5'd10; end
      endcase
      run_move(5, 0, en_cyc, en_cnt, rx, ry, done_cyc, done_cnt, rw_bad);
      chk("lfsr.en_cyc", en_cyc, 3);
      chk("lfsr.reg_x", 32'(rx), 32'(tx));
      chk("lfsr.reg_y", 32'(ry), 32'(ty));
    end
`endif

    // Counter holds while enable is low.
    @(negedge clock_50);
    reset_n = 1'b0;
    #1;
    chk("hold.rst_cnt", 32'(dut.cnt_q), 0);
    @(negedge clock_50);
    reset_n = 1'b1;
    cur_x = 5'd2; cur_y = 5'd2; pac_x = 5'd10; pac_y = 5'd3; n_walls = 0;
    enable = 1'b1;
    repeat (2) @(negedge clock_50);
    enable = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clock_50);
      if (dut.tick === 1'b1 || move_done === 1'b1) seen++;
    end
    chk("hold.cnt", 32'(dut.cnt_q), 2);
    chk("hold.activity", seen, 0);
    enable = 1'b1;
    wait_tick(lat);
    chk("hold.tick_lat", lat, 1);

    // Reset while probing abandons the move.
    @(negedge clock_50);
    enable = 1'b0;
    @(negedge clock_50);
    chk("mid.in_probe", 32'(dut.state_q), 32'(PROBE));
    #2 reset_n = 1'b0;
    #1;
    chk("mid.state", 32'(dut.state_q), 32'(IDLE));
    chk("mid.cnt", 32'(dut.cnt_q), 0);
    chk("mid.reg_en", 32'(reg_en), 0);
    chk("mid.map_x", 32'(map_x), 0);
    @(negedge clock_50);
    reset_n = 1'b1;
    run_move(8, 0, en_cyc, en_cnt, rx, ry, done_cyc, done_cnt, rw_bad);
    chk("mid.en_cnt", en_cnt, 0);
    chk("mid.done_cnt", done_cnt, 0);
    chk("mid.rw", rw_bad, 0);
    chk("mid.idle", 32'(dut.state_q), 32'(IDLE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
